// File: rtl/bullet_controller.sv
// Bullet controller: accepts fire requests from the ship, spawns single,
// double or triple volleys into an 8-entry bullet table, then moves every
// live bullet once per video frame and retires it when it leaves the screen.
module bullet_controller #(
  parameter int NUM_SLOTS       = 8,
  parameter int SHIP_X          = 320,
  parameter int SHIP_Y          = 240,
  parameter int COOLDOWN_FRAMES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        fire,
  input  logic [1:0]  fire_mode,
  input  logic [3:0]  ss_angle_state,
  output logic [7:0]  bullet_valid,
  output logic [79:0] bullet_x,
  output logic [79:0] bullet_y,
  output logic [31:0] bullet_dir,
  output logic        fire_accepted,
  output logic        busy
);

  localparam int CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [9:0] SPAWN_X = 10'(SHIP_X);
  localparam logic [9:0] SPAWN_Y = 10'(SHIP_Y);

  typedef enum logic [1:0] {
    IDLE,
    SPAWN,
    COOLDOWN
  } state_t;

  state_t state, next_state;

  logic            fire_prev;
  logic            fire_edge;
  logic [3:0]      base_angle;
  logic [1:0]      volley_mode;
  logic [1:0]      spawn_cnt;
  logic [CD_W-1:0] cd_cnt;
  logic            last_spawn;
  logic            cooldown_done;
  logic [3:0]      volley_angle;
  logic            free_found;
  logic [2:0]      free_idx;

  logic [NUM_SLOTS-1:0] slot_valid;
  logic [9:0]           slot_x   [NUM_SLOTS];
  logic [9:0]           slot_y   [NUM_SLOTS];
  logic [3:0]           slot_dir [NUM_SLOTS];
  logic signed [10:0]   next_x   [NUM_SLOTS];
  logic signed [10:0]   next_y   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] off_screen;

  // Per-frame speed for a heading; sign-extended to the 11-bit position math.
  function automatic logic signed [10:0] speed(input logic [3:0] idx);
    logic signed [3:0] s;
    case (idx)
      4'd0:    s = 4'sd0;
      4'd1:    s = 4'sd2;
      4'd2:    s = 4'sd3;
      4'd3:    s = 4'sd4;
      4'd4:    s = 4'sd4;
      4'd5:    s = 4'sd4;
      4'd6:    s = 4'sd3;
      4'd7:    s = 4'sd2;
      4'd8:    s = 4'sd0;
      4'd9:    s = -4'sd2;
      4'd10:   s = -4'sd3;
      4'd11:   s = -4'sd4;
      4'd12:   s = -4'sd4;
      4'd13:   s = -4'sd4;
      4'd14:   s = -4'sd3;
      default: s = -4'sd2;
    endcase
    return {{7{s[3]}}, s};
  endfunction

  assign fire_edge     = fire & ~fire_prev;
  assign last_spawn    = (spawn_cnt == volley_mode);
  assign cooldown_done = frame_tick && (cd_cnt == CD_W'(COOLDOWN_FRAMES - 1));

  // State register for the volley sequencer.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: accept a fire edge, spawn n bullets, then wait out the cooldown.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (fire_edge)     next_state = SPAWN;
      SPAWN:    if (last_spawn)    next_state = COOLDOWN;
      COOLDOWN: if (cooldown_done) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Volley bookkeeping: edge detect, latched angle/mode, spawn and cooldown counters, status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fire_prev     <= 1'b1;
      fire_accepted <= 1'b0;
      busy          <= 1'b0;
      base_angle    <= '0;
      volley_mode   <= '0;
      spawn_cnt     <= '0;
      cd_cnt        <= '0;
    end else begin
      fire_prev     <= fire;
      fire_accepted <= (state == IDLE) && fire_edge;
      busy          <= (next_state != IDLE);
      if (state == IDLE && fire_edge) begin
        base_angle  <= ss_angle_state;
        volley_mode <= (fire_mode == 2'd3) ? 2'd2 : fire_mode;
        spawn_cnt   <= '0;
      end else if (state == SPAWN) begin
        spawn_cnt <= spawn_cnt + 2'd1;
      end
      if (state == COOLDOWN && frame_tick) begin
        cd_cnt <= cooldown_done ? '0 : cd_cnt + 1'b1;
      end
    end
  end

  // Heading of the bullet spawned this cycle; 4-bit wrap gives the mod-16 spread.
  always_comb begin
    volley_angle = base_angle;
    case (volley_mode)
      2'd1: volley_angle = (spawn_cnt == 2'd0) ? base_angle - 4'd1 : base_angle + 4'd1;
      2'd2: begin
        case (spawn_cnt)
          2'd0:    volley_angle = base_angle - 4'd1;
          2'd1:    volley_angle = base_angle;
          default: volley_angle = base_angle + 4'd1;
        endcase
      end
      default: volley_angle = base_angle;
    endcase
  end

  // Lowest-index free slot, judged on the registered valid flags so a slot retired this cycle is not reused until the next.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  // Candidate positions after one frame of motion and whether they leave the 640x480 screen.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      next_x[i]     = $signed({1'b0, slot_x[i]}) + speed(slot_dir[i]);
      next_y[i]     = $signed({1'b0, slot_y[i]}) - speed(slot_dir[i] + 4'd4);
      off_screen[i] = (next_x[i] < 11'sd0) || (next_x[i] > 11'sd639) ||
                      (next_y[i] < 11'sd0) || (next_y[i] > 11'sd479);
    end
  end

  // Bullet table: a spawn wins over motion; an off-screen move retires the slot and keeps its last position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_x[i]   <= '0;
        slot_y[i]   <= '0;
        slot_dir[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (state == SPAWN && free_found && free_idx == 3'(i)) begin
          slot_valid[i] <= 1'b1;
          slot_x[i]     <= SPAWN_X;
          slot_y[i]     <= SPAWN_Y;
          slot_dir[i]   <= volley_angle;
        end else if (frame_tick && slot_valid[i]) begin
          if (off_screen[i]) begin
            slot_valid[i] <= 1'b0;
          end else begin
            slot_x[i] <= next_x[i][9:0];
            slot_y[i] <= next_y[i][9:0];
          end
        end
      end
    end
  end

  assign bullet_valid = slot_valid;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign bullet_x[10*g +: 10]  = slot_x[g];
    assign bullet_y[10*g +: 10]  = slot_y[g];
    assign bullet_dir[4*g +: 4]  = slot_dir[g];
  end

endmodule
